// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-port memory between the 6502 core and a
// DMA/debug port. Each access runs IDLE -> BUSY -> RESP; the CPU has priority,
// with a starvation guard that hands the bus to DMA after a run of CPU wins.
// Writes aimed at the ROM window are issued as reads and flagged.
module mem_bus_arbiter #(
  parameter int                ADDR_W      = 16,
  parameter int                DATA_W      = 8,
  parameter logic [ADDR_W-1:0] ROM_BASE    = 16'hF000,
  parameter int                CPU_RUN_MAX = 4
) (
  input  logic              ph2,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_ready,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner,
  output logic              rom_wr_err
);

  localparam int RUN_W = $clog2(CPU_RUN_MAX + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(CPU_RUN_MAX);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state, state_n;
  logic [RUN_W-1:0]  run_cnt;
  logic              acc_we;        // latched direction of the in-flight access
  logic [DATA_W-1:0] cpu_rdata_q, dma_rdata_q;
  logic              accept;
  logic              sel_we, sel_rom;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // State register; reset aborts any in-flight access.
  always_ff @(posedge ph2) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Arbitration, next state, handshakes and read-data bypass.
  always_comb begin
    state_n   = state;
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    // Grants only where a new access can start: IDLE or the RESP overlap slot.
    if (!reset && state != BUSY) begin
      dma_gnt = dma_req && (!cpu_req || run_cnt == RUN_MAX);
      cpu_gnt = cpu_req && !dma_gnt;
    end
    accept    = cpu_gnt || dma_gnt;
    sel_we    = dma_gnt ? dma_we    : cpu_we;
    sel_addr  = dma_gnt ? dma_addr  : cpu_addr;
    sel_wdata = dma_gnt ? dma_wdata : cpu_wdata;
    sel_rom   = sel_addr >= ROM_BASE;
    case (state)
      IDLE:    if (accept) state_n = BUSY;
      BUSY:    state_n = RESP;
      RESP:    state_n = accept ? BUSY : IDLE;
      default: state_n = IDLE;
    endcase
    cpu_ready = !reset && state == RESP && !owner;
    dma_ready = !reset && state == RESP &&  owner;
    cpu_rdata = (cpu_ready && !acc_we) ? mem_rdata : cpu_rdata_q;
    dma_rdata = (dma_ready && !acc_we) ? mem_rdata : dma_rdata_q;
  end

  // Memory command latch, read-data capture, run counter and ROM flag.
  always_ff @(posedge ph2) begin
    if (reset) begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      owner       <= 1'b0;
      acc_we      <= 1'b0;
      rom_wr_err  <= 1'b0;
      run_cnt     <= '0;
      cpu_rdata_q <= '0;
      dma_rdata_q <= '0;
    end else begin
      // Strobe is high exactly in BUSY; ROM writes are demoted to reads.
      mem_en <= accept;
      mem_we <= accept && sel_we && !sel_rom;
      if (accept) begin
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
        owner     <= dma_gnt;
        acc_we    <= sel_we;
        if (sel_we && sel_rom) rom_wr_err <= 1'b1;
      end
      if (cpu_ready && !acc_we) cpu_rdata_q <= mem_rdata;
      if (dma_ready && !acc_we) dma_rdata_q <= mem_rdata;
      if (dma_gnt) begin
        run_cnt <= '0;
      end else if (cpu_gnt) begin
        if (!dma_req)              run_cnt <= '0;
        else if (run_cnt != RUN_MAX) run_cnt <= run_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios followed by
// randomized traffic, all compared each cycle against a transaction-level model.
module tb_mem_bus_arbiter;

  localparam int MAX = 4;
  localparam logic [15:0] ROMB = 16'hF000;

  logic        ph2 = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 0, cpu_we = 0, dma_req = 0, dma_we = 0;
  logic [15:0] cpu_addr = 0, dma_addr = 0;
  logic [7:0]  cpu_wdata = 0, dma_wdata = 0;
  logic        cpu_gnt, cpu_ready, dma_gnt, dma_ready;
  logic [7:0]  cpu_rdata, dma_rdata;
  logic        mem_en, mem_we, owner, rom_wr_err;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;

  mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .ROM_BASE(16'hF000), .CPU_RUN_MAX(MAX)) dut (
    .ph2(ph2), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_gnt(dma_gnt), .dma_ready(dma_ready), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .owner(owner), .rom_wr_err(rom_wr_err)
  );

  always #5 ph2 = ~ph2;

  // Power-on memory contents (0x00A9 holds 0xAA for the first read scenario).
  function automatic logic [7:0] init_val(input logic [15:0] a);
    if (a == 16'h00A9) return 8'hAA;
    return a[7:0] ^ a[15:8];
  endfunction

  // Memory: one-cycle read latency behind mem_en.
  logic [7:0] tmem [0:65535];
  bit         tvld [0:65535];
  always @(posedge ph2) begin
    if (mem_en) begin
      if (mem_we) begin
        tmem[mem_addr] <= mem_wdata;
        tvld[mem_addr] <= 1'b1;
      end
      mem_rdata <= tvld[mem_addr] ? tmem[mem_addr] : init_val(mem_addr);
    end
  end

  // Reference model: transaction phase since last accept, fairness count, memory image.
  int          phase;          // 0 none, 1 command cycle, 2 response cycle
  int          run;
  bit          m_owner, m_we, m_err;
  logic [15:0] m_addr;
  logic [7:0]  m_wd, exp_crd, exp_drd;
  logic [7:0]  ref_mem [0:65535];
  int          checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst,
                      input bit cr, input bit cw, input logic [15:0] ca, input logic [7:0] cd,
                      input bit dr, input bit dw, input logic [15:0] da, input logic [7:0] dd,
                      output bit o_cg, output bit o_dg, output bit o_cr, output bit o_dr);
    bit arb, eg_c, eg_d, er_c, er_d;
    @(negedge ph2);
    reset = rst;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd;
    #1;
    arb  = !rst && phase != 1;
    eg_d = arb && dr && (!cr || run == MAX);
    eg_c = arb && cr && !eg_d;
    er_c = !rst && phase == 2 && !m_owner;
    er_d = !rst && phase == 2 &&  m_owner;
    chk("cpu_gnt", cpu_gnt, eg_c);
    chk("dma_gnt", dma_gnt, eg_d);
    chk("cpu_ready", cpu_ready, er_c);
    chk("dma_ready", dma_ready, er_d);
    chk("cpu_rdata", cpu_rdata, (er_c && !m_we) ? ref_mem[m_addr] : exp_crd);
    chk("dma_rdata", dma_rdata, (er_d && !m_we) ? ref_mem[m_addr] : exp_drd);
    chk("mem_en", mem_en, phase == 1);
    chk("owner", owner, m_owner);
    chk("rom_wr_err", rom_wr_err, m_err);
    if (phase == 1) begin
      chk("mem_we", mem_we, m_we && m_addr < ROMB);
      chk("mem_addr", mem_addr, m_addr);
      if (m_we) chk("mem_wdata", mem_wdata, m_wd);
    end
    o_cg = cpu_gnt; o_dg = dma_gnt; o_cr = cpu_ready; o_dr = dma_ready;
    @(posedge ph2);
    // The memory sees the strobe of the command cycle even if reset is high.
    if (phase == 1 && m_we && m_addr < ROMB) ref_mem[m_addr] = m_wd;
    if (rst) begin
      phase = 0; run = 0; m_owner = 0; m_err = 0; m_we = 0;
      exp_crd = 0; exp_drd = 0;
    end else begin
      if (phase == 2 && !m_we) begin
        if (m_owner) exp_drd = ref_mem[m_addr];
        else         exp_crd = ref_mem[m_addr];
      end
      if (eg_d) run = 0;
      else if (eg_c) run = dr ? ((run < MAX) ? run + 1 : MAX) : 0;
      if (eg_c || eg_d) begin
        m_owner = eg_d;
        m_we    = eg_d ? dw : cw;
        m_addr  = eg_d ? da : ca;
        m_wd    = eg_d ? dd : cd;
        if (m_we && m_addr >= ROMB) m_err = 1;
        phase = 1;
      end else begin
        phase = (phase == 1) ? 2 : 0;
      end
    end
  endtask

  task automatic idle(input int n);
    bit a, b, c, d;
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, a, b, c, d);
  endtask

  initial begin
    bit g_c, g_d, r_c, r_d, any_dr;
    bit seq [$];
    bit exp_seq [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    logic [15:0] pool [8] = '{16'h0010, 16'h0011, 16'h0012, 16'h00A9,
                              16'hEFFF, 16'hF000, 16'hF123, 16'hFFFF};
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(16'(i));
    phase = 0; run = 0; m_owner = 0; m_err = 0; m_we = 0; m_addr = 0; m_wd = 0;
    exp_crd = 0; exp_drd = 0;

    // 1: reset for two cycles, then quiet bus
    @(negedge ph2); reset = 1;
    repeat (2) @(posedge ph2);
    idle(2);

    // 2: CPU read of 0x00A9
    step(0, 1, 0, 16'h00A9, 0, 0, 0, 0, 0, g_c, g_d, r_c, r_d);
    chk("t2_gnt", g_c, 1);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g_c, g_d, r_c, r_d);
    chk("t2_ready", r_c, 1);
    idle(3);
    chk("t2_hold", cpu_rdata, 8'hAA);

    // 3: both ports saturating the bus
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 16'h0011, 0, 1, 0, 16'h0012, 0, g_c, g_d, r_c, r_d);
      chk("t3_one_gnt", g_c & g_d, 0);
      if (g_c || g_d) seq.push_back(g_d);
    end
    chk("t3_count", seq.size(), 10);
    for (int i = 0; i < 10 && i < seq.size(); i++) chk("t3_order", seq[i], exp_seq[i]);
    idle(2);

    // 4: DMA write into ROM is blocked and flagged
    step(0, 0, 0, 0, 0, 1, 1, 16'hF000, 8'h55, g_c, g_d, r_c, r_d);
    chk("t4_gnt", g_d, 1);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g_c, g_d, r_c, r_d);
    chk("t4_ready", r_d, 1);
    idle(4);
    chk("t4_err", rom_wr_err, 1);

    // 5: CPU write then back-to-back read of the same RAM byte
    step(0, 1, 1, 16'h0010, 8'h3C, 0, 0, 0, 0, g_c, g_d, r_c, r_d);
    idle(1);
    step(0, 1, 0, 16'h0010, 0, 0, 0, 0, 0, g_c, g_d, r_c, r_d);
    chk("t5_overlap_gnt", g_c, 1);
    chk("t5_overlap_rdy", r_c, 1);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, g_c, g_d, r_c, r_d);
    chk("t5_ready", r_c, 1);
    chk("t5_rdata", cpu_rdata, 8'h3C);
    idle(1);

    // 6: reset during the command cycle of a DMA read
    step(0, 0, 0, 0, 0, 1, 0, 16'h0012, 0, g_c, g_d, r_c, r_d);
    chk("t6_gnt", g_d, 1);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, g_c, g_d, r_c, r_d);
    any_dr = 0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0, g_c, g_d, r_c, r_d);
      any_dr |= r_d;
    end
    chk("t6_no_ready", any_dr, 0);
    chk("t6_owner", owner, 0);
    chk("t6_err_clr", rom_wr_err, 0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 49) == 0,
           $urandom_range(0, 2) != 0, 1'($urandom), pool[$urandom_range(0, 7)], 8'($urandom),
           $urandom_range(0, 2) != 0, 1'($urandom), pool[$urandom_range(0, 7)], 8'($urandom),
           g_c, g_d, r_c, r_d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
